// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants, opcodes and fetch state encoding
package core_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
  localparam int unsigned PC_INC       = 4;

  // Opcodes decoded by the hazard detector in ID
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction memory request/stall port
interface if_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_ren;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_stall;

  modport master (output imem_ren, output imem_addr, input imem_rdata, input imem_stall);
  modport slave  (input imem_ren, input imem_addr, output imem_rdata, output imem_stall);
endinterface

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry {pc,inst} skid buffer for held IF/ID
module fetch_skid_buf #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [31:0]       push_inst,
  output logic              valid,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       inst
);

  always_ff @(posedge clk) begin
    if (rst || clear) valid <= 1'b0;
    else if (push)    valid <= 1'b1;
    else if (pop)     valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc   <= '0;
      inst <= '0;
    end else if (push && !clear) begin
      pc   <= push_pc;
      inst <= push_inst;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - PC, I-memory request port and IF/ID register
module if_fetch_unit
  import core_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter logic [31:0]       NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pcwrite,
  input  logic              if_id_write,
  input  logic              if_flush,
  input  logic [ADDR_W-1:0] redirect_pc,
  if_fetch_unit_if.master   imem,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [31:0]       if_id_inst,
  output logic              if_id_valid,
  output logic              fetch_stall
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pend_pc_q;
  logic              out_q;
  logic              ren, acc, stalled;
  logic              skid_valid, skid_push, skid_pop;
  logic [ADDR_W-1:0] skid_pc;
  logic [31:0]       skid_inst;
  logic [ADDR_W-1:0] redirect_aligned;

  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

  // A stalled request keeps ren high even if pcwrite rises, so the address never moves mid-access
  assign ren = (state_q == DRAIN) ||
               ((state_q == FETCH) && !skid_valid && (!pcwrite || out_q));
  assign acc     = ren && !imem.imem_stall;
  assign stalled = ren && imem.imem_stall;

  assign imem.imem_ren  = ren;
  assign imem.imem_addr = pc_q;
  assign fetch_stall    = (state_q == FETCH) && stalled;

  assign skid_push = acc && (state_q == FETCH) && if_id_write && !if_flush;
  assign skid_pop  = skid_valid && !if_id_write && !if_flush;

  fetch_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (skid_push),
    .pop       (skid_pop),
    .clear     (if_flush),
    .push_pc   (pc_q),
    .push_inst (imem.imem_rdata),
    .valid     (skid_valid),
    .pc        (skid_pc),
    .inst      (skid_inst)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   state_d = FETCH;
      DRAIN:   if (acc) state_d = FETCH;
      default: state_d = IDLE;
    endcase
    if (if_flush) state_d = stalled ? DRAIN : FETCH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      pend_pc_q   <= '0;
      out_q       <= 1'b0;
      if_id_pc    <= '0;
      if_id_inst  <= NOP_INST;
      if_id_valid <= 1'b0;
    end else begin
      out_q <= stalled;
      if (if_flush) begin
        if_id_inst  <= NOP_INST;
        if_id_valid <= 1'b0;
        if (stalled) pend_pc_q <= redirect_aligned;
        else         pc_q      <= redirect_aligned;
      end else begin
        // In DRAIN the accepted word belongs to the killed path and is dropped
        if (acc) pc_q <= (state_q == DRAIN) ? pend_pc_q : pc_q + ADDR_W'(PC_INC);
        if (!if_id_write) begin
          if (acc && (state_q == FETCH)) begin
            if_id_pc    <= pc_q;
            if_id_inst  <= imem.imem_rdata;
            if_id_valid <= 1'b1;
          end else if (skid_valid) begin
            if_id_pc    <= skid_pc;
            if_id_inst  <= skid_inst;
            if_id_valid <= 1'b1;
          end else begin
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - randomized self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, pcwrite, if_id_write, if_flush;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_pc, if_id_inst;
  logic        if_id_valid, fetch_stall;

  if_fetch_unit_if #(.ADDR_W(32)) imem ();

  if_fetch_unit #(.ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .pcwrite     (pcwrite),
    .if_id_write (if_id_write),
    .if_flush    (if_flush),
    .redirect_pc (redirect_pc),
    .imem        (imem),
    .if_id_pc    (if_id_pc),
    .if_id_inst  (if_id_inst),
    .if_id_valid (if_id_valid),
    .fetch_stall (fetch_stall)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference view: next fetch address, a pending redirect whose stalled word must be dropped,
  // a FIFO of captured-but-held instructions, and the instruction sitting in ID.
  bit          m_known = 0, m_started = 0, m_discard = 0, m_out = 0;
  logic [31:0] m_pc, m_target, m_id_pc, m_id_inst;
  bit          m_id_valid;
  logic [63:0] m_held[$];

  logic [31:0] last_rd;
  bit          obs_ren, obs_fs;
  logic [31:0] obs_addr;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit exp_ren();
    if (!m_started) return 1'b0;
    if (m_discard)  return 1'b1;
    return (m_held.size() == 0) && (!pcwrite || m_out);
  endfunction

  task automatic compare();
    bit er;
    if (!m_known) return;
    er = exp_ren();
    chk("imem_ren",    32'(imem.imem_ren), 32'(er));
    chk("imem_addr",   imem.imem_addr, m_pc);
    chk("fetch_stall", 32'(fetch_stall), 32'(er && imem.imem_stall && !m_discard));
    chk("if_id_pc",    if_id_pc, m_id_pc);
    chk("if_id_inst",  if_id_inst, m_id_inst);
    chk("if_id_valid", 32'(if_id_valid), 32'(m_id_valid));
  endtask

  task automatic model_edge();
    bit er, acc, held, took;
    logic [63:0] e;
    if (rst) begin
      m_known = 1; m_started = 0; m_discard = 0; m_out = 0;
      m_pc = 32'h0; m_target = 32'h0; m_held.delete();
      m_id_pc = 32'h0; m_id_inst = NOP; m_id_valid = 0;
      return;
    end
    er   = exp_ren();
    acc  = er && !imem.imem_stall;
    held = er && imem.imem_stall;
    if (if_flush) begin
      m_held.delete();
      m_id_inst = NOP; m_id_valid = 0;
      if (held) begin m_discard = 1; m_target = redirect_pc & ~32'h3; end
      else begin m_discard = 0; m_pc = redirect_pc & ~32'h3; end
    end else begin
      took = 0;
      if (acc && m_discard) begin
        m_pc = m_target; m_discard = 0;
      end else if (acc) begin
        if (if_id_write) m_held.push_back({m_pc, imem.imem_rdata});
        else begin m_id_pc = m_pc; m_id_inst = imem.imem_rdata; m_id_valid = 1; took = 1; end
        m_pc = m_pc + 32'd4;
      end
      if (!if_id_write && !took) begin
        if (m_held.size() > 0) begin
          e = m_held.pop_front();
          m_id_pc = e[63:32]; m_id_inst = e[31:0]; m_id_valid = 1;
        end else begin
          m_id_inst = NOP; m_id_valid = 0;
        end
      end
    end
    m_started = 1;
    m_out = held;
  endtask

  task automatic step(input bit r, input bit pw, input bit iw, input bit fl,
                      input logic [31:0] rpc, input bit st);
    @(negedge clk);
    rst = r; pcwrite = pw; if_id_write = iw; if_flush = fl; redirect_pc = rpc;
    imem.imem_stall = st;
    last_rd = $urandom;
    imem.imem_rdata = last_rd;
    #1;
    obs_ren = imem.imem_ren; obs_addr = imem.imem_addr; obs_fs = fetch_stall;
    compare();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(3) == 0) return 32'hFFFF_FFF0 | ($urandom & 32'hF);
    return $urandom;
  endfunction

  logic [31:0] rd_keep;

  initial begin
    rst = 1; pcwrite = 0; if_id_write = 0; if_flush = 0; redirect_pc = 0;
    imem.imem_stall = 0; imem.imem_rdata = 0;

    repeat (3) step(1, 0, 0, 0, 0, 0);
    chk("rst_valid", 32'(if_id_valid), 32'h0);
    chk("rst_inst",  if_id_inst, NOP);
    chk("rst_pc",    if_id_pc, 32'h0);
    chk("rst_ren",   32'(obs_ren), 32'h0);

    step(0, 0, 0, 0, 0, 0);
    chk("idle_ren", 32'(obs_ren), 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("first_addr",  obs_addr, 32'h0);
    chk("first_valid", 32'(if_id_valid), 32'h1);
    chk("first_pc",    if_id_pc, 32'h0);
    chk("first_inst",  if_id_inst, last_rd);
    for (int i = 1; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("seq_addr", obs_addr, 32'(i * 4));
    end

    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1);
      chk("stall_addr", obs_addr, 32'h10);
      chk("stall_fs",   32'(obs_fs), 32'h1);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("after_stall_pc",   if_id_pc, 32'h10);
    chk("after_stall_inst", if_id_inst, last_rd);

    step(0, 0, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0);
    rd_keep = last_rd;
    chk("lu_hold_pc", if_id_pc, 32'h10);
    step(0, 0, 0, 0, 0, 0);
    chk("lu_skid_ren",  32'(obs_ren), 32'h0);
    chk("lu_skid_pc",   if_id_pc, 32'h14);
    chk("lu_skid_inst", if_id_inst, rd_keep);
    step(0, 0, 0, 0, 0, 0);
    chk("lu_next_addr", obs_addr, 32'h18);

    step(0, 0, 0, 1, 32'h100, 0);
    chk("fl_valid", 32'(if_id_valid), 32'h0);
    chk("fl_inst",  if_id_inst, NOP);
    step(0, 0, 0, 0, 0, 0);
    chk("fl_addr", obs_addr, 32'h100);

    step(0, 0, 0, 1, 32'h20, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 32'h200, 1);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 0, 1);
      chk("drain_addr", obs_addr, 32'h20);
      chk("drain_fs",   32'(obs_fs), 32'h0);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("drain_valid", 32'(if_id_valid), 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("drain_next_addr", obs_addr, 32'h200);

    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("midrst_ren",  32'(imem.imem_ren), 32'h0);
    chk("midrst_addr", imem.imem_addr, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("midrst_valid", 32'(if_id_valid), 32'h0);

    step(0, 0, 0, 1, 32'hFFFF_FFFE, 0);
    chk("wrap_redirect", imem.imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 0);
    chk("wrap_addr", imem.imem_addr, 32'h0);
    chk("wrap_pc",   if_id_pc, 32'hFFFF_FFFC);

    for (int i = 0; i < 4000; i++) begin
      logic [31:0] rpc;
      rpc = rand_pc();
      step($urandom_range(149) == 0, $urandom_range(4) == 0, $urandom_range(3) == 0,
           $urandom_range(11) == 0, rpc, $urandom_range(2) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
